// File: rtl/cnn_window_sched.sv
// Sliding-window read scheduler: walks a KxK window across an IMG_W x IMG_H
// image held in RAM, issuing one tap read per cycle and tagging the delayed data.
module cnn_window_sched #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic              core_bsy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tap_vld,
  output logic [3:0]        tap_idx,
  output logic              win_first,
  output logic              win_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int NTAP = K * K;
  localparam logic [3:0]        TAP_LAST = 4'(NTAP - 1);
  localparam logic [3:0]        TC_LAST  = 4'(K - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - K);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - K);
  localparam logic [ADDR_W-1:0] WIN_SPAN = ADDR_W'((K - 1) * IMG_W + K - 1);
  // Jump from the last column of one tap row to the first column of the next.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - K + 1);
  localparam logic [ADDR_W-1:0] STEP_K   = ADDR_W'(K);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [3:0]        r_tap;
  logic [3:0]        r_tc;
  logic              r_rd_en;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_tap_vld;
  logic [3:0]        r_tap_idx;
  logic              r_win_first;
  logic              r_win_last;

  logic w_data_rdy;
  logic w_last_tap;
  logic w_last_col;
  logic w_last_row;

  // The window's bottom-right pixel must already be in RAM before issuing.
  assign w_data_rdy = (r_base + WIN_SPAN) < wr_ptr;
  assign w_last_tap = (r_tap == TAP_LAST);
  assign w_last_col = (r_col == COL_LAST);
  assign w_last_row = (r_row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_base       <= '0;
      r_rd_addr    <= '0;
      r_tap        <= '0;
      r_tc         <= '0;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (abort) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_base       <= '0;
      r_rd_addr    <= '0;
      r_tap        <= '0;
      r_tc         <= '0;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_frame_done <= 1'b0;
          if (start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_base  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_data_rdy && !core_bsy) begin
            r_state   <= S_ISSUE;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_base;
            r_tap     <= '0;
            r_tc      <= '0;
          end
        end
        S_ISSUE: begin
          if (w_last_tap) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_tap     <= '0;
            r_tc      <= '0;
            if (!w_last_col) begin
              r_col   <= r_col + ONE;
              r_base  <= r_base + ONE;
              r_state <= S_WAIT;
            end else if (!w_last_row) begin
              r_col   <= '0;
              r_row   <= r_row + ONE;
              r_base  <= r_base + STEP_K;
              r_state <= S_WAIT;
            end else begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end
          end else begin
            r_tap <= r_tap + 4'd1;
            if (r_tc == TC_LAST) begin
              r_tc      <= '0;
              r_rd_addr <= r_rd_addr + ROW_STEP;
            end else begin
              r_tc      <= r_tc + 4'd1;
              r_rd_addr <= r_rd_addr + ONE;
            end
          end
        end
        S_DONE: begin
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
          r_row        <= '0;
          r_col        <= '0;
          r_base       <= '0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tap tags follow the RAM read by one cycle; abort does not cancel a read already issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tap_vld   <= 1'b0;
      r_tap_idx   <= '0;
      r_win_first <= 1'b0;
      r_win_last  <= 1'b0;
    end else begin
      r_tap_vld   <= r_rd_en;
      r_tap_idx   <= r_rd_en ? r_tap : 4'd0;
      r_win_first <= r_rd_en && (r_tap == 4'd0);
      r_win_last  <= r_rd_en && w_last_tap;
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign tap_vld    = r_tap_vld;
  assign tap_idx    = r_tap_idx;
  assign win_first  = r_win_first;
  assign win_last   = r_win_last;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
